// File: rtl/sd_rw_sched.sv
// Purpose : arbitrates one SD controller between a sector writer (ring-buffer address)
//           and a sector reader; issues start pulses and tracks the busy handshake.
// Latency : request -> start pulse on the cycle after the grant edge; busy fall -> done next edge.
// Backpr. : requesters hold req until done; no grant while card not ready or either busy is high.
// Ports   : clk_ref/rst_n clock and async active-low reset; sd_init_done card ready;
//           wr_req/wr_done and rd_req/rd_addr/rd_done requester handshakes;
//           wr_start_en/wr_sec_addr/wr_busy and rd_start_en/rd_sec_addr/rd_busy controller side;
//           err_to busy-timeout pulse, wrap sticky ring wrap flag, wr_cnt saturating write count.
module sd_rw_sched #(
  parameter logic [31:0] SEC_START = 32'd2048,
  parameter logic [31:0] SEC_NUM   = 32'd1024,
  parameter logic [15:0] BUSY_TO   = 16'd50000
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        wr_req,
  output logic        wr_done,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_done,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  input  logic        wr_busy,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  input  logic        rd_busy,
  output logic        err_to,
  output logic        wrap,
  output logic [31:0] wr_cnt
);

  typedef enum logic [2:0] {
    IDLE, WR_GO, WR_WBSY, WR_WDONE, RD_GO, RD_WBSY, RD_WDONE
  } state_t;

  localparam logic [31:0] SEC_LAST = SEC_START + SEC_NUM - 32'd1;

  state_t      r_state;
  logic        r_last_rd;
  logic [15:0] r_to_cnt;
  logic        r_wr_start;
  logic        r_rd_start;
  logic        r_wr_done;
  logic        r_rd_done;
  logic        r_err_to;
  logic        r_wrap;
  logic [31:0] r_wr_sec_addr;
  logic [31:0] r_rd_sec_addr;
  logic [31:0] r_wr_cnt;

  logic        w_grant_ok;
  logic        w_pick_wr;
  logic        w_pick_rd;
  logic [15:0] w_to_cnt_nxt;
  logic        w_to_hit;

  // Foreign controller activity (either busy high) blocks any new grant.
  assign w_grant_ok   = sd_init_done & ~wr_busy & ~rd_busy;
  // Round-robin on a tie: the side that did not win last time goes first.
  assign w_pick_wr    = wr_req & (~rd_req | r_last_rd);
  assign w_pick_rd    = rd_req & (~wr_req | ~r_last_rd);
  // Timeout fires when the incremented count reaches BUSY_TO-1 (BUSY_TO must be >= 2).
  assign w_to_cnt_nxt = r_to_cnt + 16'd1;
  assign w_to_hit     = (w_to_cnt_nxt == (BUSY_TO - 16'd1));

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last_rd     <= 1'b1;
      r_to_cnt      <= 16'd0;
      r_wr_start    <= 1'b0;
      r_rd_start    <= 1'b0;
      r_wr_done     <= 1'b0;
      r_rd_done     <= 1'b0;
      r_err_to      <= 1'b0;
      r_wrap        <= 1'b0;
      r_wr_sec_addr <= SEC_START;
      r_rd_sec_addr <= 32'd0;
      r_wr_cnt      <= 32'd0;
    end else begin
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_wr_done  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_err_to   <= 1'b0;
      if (r_state != IDLE && !sd_init_done) begin
        // Card lost: drop the transaction silently; requests stay pending.
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_grant_ok) begin
              if (w_pick_wr) begin
                r_state    <= WR_GO;
                r_wr_start <= 1'b1;
                r_last_rd  <= 1'b0;
              end else if (w_pick_rd) begin
                r_state       <= RD_GO;
                r_rd_start    <= 1'b1;
                r_last_rd     <= 1'b1;
                r_rd_sec_addr <= rd_addr;
              end
            end
          end
          WR_GO: begin
            r_state  <= WR_WBSY;
            r_to_cnt <= 16'd0;
          end
          WR_WBSY: begin
            if (wr_busy) begin
              r_state <= WR_WDONE;
            end else if (w_to_hit) begin
              r_err_to <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_to_cnt <= w_to_cnt_nxt;
            end
          end
          WR_WDONE: begin
            if (!wr_busy) begin
              r_wr_done <= 1'b1;
              r_state   <= IDLE;
              if (r_wr_sec_addr == SEC_LAST) begin
                r_wr_sec_addr <= SEC_START;
                r_wrap        <= 1'b1;
              end else begin
                r_wr_sec_addr <= r_wr_sec_addr + 32'd1;
              end
              if (r_wr_cnt != 32'hFFFF_FFFF) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
              end
            end
          end
          RD_GO: begin
            r_state  <= RD_WBSY;
            r_to_cnt <= 16'd0;
          end
          RD_WBSY: begin
            if (rd_busy) begin
              r_state <= RD_WDONE;
            end else if (w_to_hit) begin
              r_err_to <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_to_cnt <= w_to_cnt_nxt;
            end
          end
          RD_WDONE: begin
            if (!rd_busy) begin
              r_rd_done <= 1'b1;
              r_state   <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign wr_start_en = r_wr_start;
  assign rd_start_en = r_rd_start;
  assign wr_done     = r_wr_done;
  assign rd_done     = r_rd_done;
  assign err_to      = r_err_to;
  assign wrap        = r_wrap;
  assign wr_sec_addr = r_wr_sec_addr;
  assign rd_sec_addr = r_rd_sec_addr;
  assign wr_cnt      = r_wr_cnt;

endmodule

// File: tb/tb_sd_rw_sched.sv
// Purpose : directed self-checking bench for sd_rw_sched with a small busy-handshake controller model.
// Latency : expected cycle offsets are hand-derived from the negedge-sampled start/done/err events.
// Backpr. : requests are held until the matching done pulse, then dropped in the same cycle.
module tb_sd_rw_sched;

  localparam logic [31:0] SEC_START = 32'd2048;
  localparam logic [31:0] SEC_NUM   = 32'd4;
  localparam logic [15:0] BUSY_TO   = 16'd16;

  logic        clk_ref;
  logic        rst_n;
  logic        sd_init_done;
  logic        wr_req;
  logic        wr_done;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_done;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        wr_busy;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        err_to;
  logic        wrap;
  logic [31:0] wr_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit wr_model_en = 1'b1;
  bit rd_model_en = 1'b1;

  int          st_kind[$];  // 0 = write start, 1 = read start
  logic [31:0] st_addr[$];
  int          st_cyc[$];
  int n_wr_done = 0;
  int n_rd_done = 0;
  int n_err = 0;
  int err_cyc = 0;
  int wr_done_cyc = 0;

  sd_rw_sched #(.SEC_START(SEC_START), .SEC_NUM(SEC_NUM), .BUSY_TO(BUSY_TO)) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .sd_init_done(sd_init_done),
    .wr_req(wr_req), .wr_done(wr_done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_busy(wr_busy),
    .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .rd_busy(rd_busy),
    .err_to(err_to), .wrap(wrap), .wr_cnt(wr_cnt)
  );

  initial begin
    clk_ref = 1'b0;
    forever #5 clk_ref = ~clk_ref;
  end

  initial forever begin
    @(posedge clk_ref);
    cyc++;
  end

  // Event log, sampled on the falling edge.
  initial forever begin
    @(negedge clk_ref);
    if (wr_start_en) begin st_kind.push_back(0); st_addr.push_back(wr_sec_addr); st_cyc.push_back(cyc); end
    if (rd_start_en) begin st_kind.push_back(1); st_addr.push_back(rd_sec_addr); st_cyc.push_back(cyc); end
    if (wr_done) begin n_wr_done++; wr_done_cyc = cyc; end
    if (rd_done) n_rd_done++;
    if (err_to) begin n_err++; err_cyc = cyc; end
  end

  // Controller model: busy rises 3 cycles after the start pulse and stays high 10 cycles.
  initial begin
    wr_busy = 1'b0;
    forever begin
      @(negedge clk_ref);
      if (wr_start_en && wr_model_en) begin
        repeat (3) @(negedge clk_ref);
        wr_busy = 1'b1;
        repeat (10) @(negedge clk_ref);
        wr_busy = 1'b0;
      end
    end
  end

  initial begin
    rd_busy = 1'b0;
    forever begin
      @(negedge clk_ref);
      if (rd_start_en && rd_model_en) begin
        repeat (3) @(negedge clk_ref);
        rd_busy = 1'b1;
        repeat (10) @(negedge clk_ref);
        rd_busy = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_ref);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    sd_init_done = 1'b1;
    repeat (15) tick();
    st_kind.delete(); st_addr.delete(); st_cyc.delete();
    n_wr_done = 0; n_rd_done = 0; n_err = 0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sd_init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_addr = 32'd0;
    repeat (3) tick();
    checks++; if (wr_sec_addr !== 32'd2048) $display("FAIL reset_wr_addr: got %0d expected 2048", wr_sec_addr);
    if (wr_sec_addr !== 32'd2048) errors++;
    checks++; if (rd_sec_addr !== 32'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_sec_addr); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    checks++;
    if ({wr_start_en, rd_start_en, wr_done, rd_done, err_to} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 00000", {wr_start_en, rd_start_en, wr_done, rd_done, err_to});
    end
  endtask

  task automatic test_single_write();
    int req_cyc;
    do_reset();
    req_cyc = cyc;
    wr_req = 1'b1;
    for (int i = 0; i < 100 && n_wr_done == 0; i++) tick();
    wr_req = 1'b0;
    checks++; if (n_wr_done != 1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", n_wr_done); end
    checks++; if (st_kind.size() != 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", st_kind.size()); end
    checks++; if (st_addr[0] !== 32'd2048) begin errors++; $display("FAIL single_addr: got %0d expected 2048", st_addr[0]); end
    checks++; if (st_cyc[0] - req_cyc != 1) begin errors++; $display("FAIL single_req_to_start: got %0d expected 1", st_cyc[0] - req_cyc); end
    checks++; if (wr_done_cyc - st_cyc[0] != 14) begin errors++; $display("FAIL single_start_to_done: got %0d expected 14", wr_done_cyc - st_cyc[0]); end
    checks++; if (wr_sec_addr !== 32'd2049) begin errors++; $display("FAIL single_next_addr: got %0d expected 2049", wr_sec_addr); end
    checks++; if (wr_cnt !== 32'd1) begin errors++; $display("FAIL single_wr_cnt: got %0d expected 1", wr_cnt); end
    repeat (20) tick();
    checks++; if (st_kind.size() != 1) begin errors++; $display("FAIL single_no_regrant: got %0d starts expected 1", st_kind.size()); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL single_no_err: got %0d expected 0", n_err); end
  endtask

  task automatic test_round_robin();
    int pat;
    do_reset();
    rd_addr = 32'h10;
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 300 && n_rd_done < 2; i++) tick();
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (20) tick();
    checks++; if (st_kind.size() != 4) begin errors++; $display("FAIL rr_starts: got %0d expected 4", st_kind.size()); end
    pat = st_kind[0] * 8 + st_kind[1] * 4 + st_kind[2] * 2 + st_kind[3];
    checks++; if (pat != 5) begin errors++; $display("FAIL rr_order: got %b expected 0101 (W,R,W,R)", pat[3:0]); end
    checks++; if (st_addr[1] !== 32'h10 || st_addr[3] !== 32'h10) begin
      errors++; $display("FAIL rr_rd_addr: got %h/%h expected 10/10", st_addr[1], st_addr[3]);
    end
    checks++; if (st_addr[0] !== 32'd2048 || st_addr[2] !== 32'd2049) begin
      errors++; $display("FAIL rr_wr_addr: got %0d/%0d expected 2048/2049", st_addr[0], st_addr[2]);
    end
    checks++; if (n_wr_done != 2) begin errors++; $display("FAIL rr_wr_done: got %0d expected 2", n_wr_done); end
  endtask

  task automatic test_timeout();
    int first_err;
    do_reset();
    rd_model_en = 1'b0;
    rd_addr = 32'h55;
    rd_req = 1'b1;
    for (int i = 0; i < 100 && n_err == 0; i++) tick();
    first_err = err_cyc;
    checks++; if (n_err != 1) begin errors++; $display("FAIL to_err_seen: got %0d expected 1", n_err); end
    checks++; if (first_err - st_cyc[0] != 16) begin errors++; $display("FAIL to_latency: got %0d expected 16", first_err - st_cyc[0]); end
    for (int i = 0; i < 10 && st_kind.size() < 2; i++) tick();
    rd_req = 1'b0;
    checks++; if (st_kind.size() != 2 || st_kind[1] != 1) begin errors++; $display("FAIL to_retry: got %0d starts expected 2", st_kind.size()); end
    checks++; if (st_cyc[1] - first_err != 1) begin errors++; $display("FAIL to_retry_gap: got %0d expected 1", st_cyc[1] - first_err); end
    for (int i = 0; i < 100 && n_err < 2; i++) tick();
    repeat (10) tick();
    checks++; if (n_err != 2) begin errors++; $display("FAIL to_second_err: got %0d expected 2", n_err); end
    checks++; if (n_rd_done != 0) begin errors++; $display("FAIL to_no_done: got %0d expected 0", n_rd_done); end
    checks++; if (st_kind.size() != 2) begin errors++; $display("FAIL to_no_more_grant: got %0d expected 2", st_kind.size()); end
    checks++; if (rd_sec_addr !== 32'h55) begin errors++; $display("FAIL to_rd_addr: got %h expected 55", rd_sec_addr); end
    rd_model_en = 1'b1;
  endtask

  task automatic test_init_drop();
    do_reset();
    wr_req = 1'b1;
    for (int i = 0; i < 50 && wr_busy !== 1'b1; i++) tick();
    repeat (2) tick();
    sd_init_done = 1'b0;
    repeat (30) tick();
    checks++; if (n_wr_done != 0) begin errors++; $display("FAIL drop_no_done: got %0d expected 0", n_wr_done); end
    checks++; if (wr_sec_addr !== 32'd2048) begin errors++; $display("FAIL drop_addr: got %0d expected 2048", wr_sec_addr); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL drop_wr_cnt: got %0d expected 0", wr_cnt); end
    checks++; if (st_kind.size() != 1) begin errors++; $display("FAIL drop_no_grant: got %0d starts expected 1", st_kind.size()); end
    sd_init_done = 1'b1;
    for (int i = 0; i < 100 && n_wr_done == 0; i++) tick();
    wr_req = 1'b0;
    checks++; if (st_kind.size() != 2 || st_addr[1] !== 32'd2048) begin
      errors++; $display("FAIL drop_retry: got %0d starts addr %0d expected 2 starts addr 2048", st_kind.size(), st_addr[1]);
    end
    checks++; if (wr_sec_addr !== 32'd2049 || wr_cnt !== 32'd1) begin
      errors++; $display("FAIL drop_complete: got addr %0d cnt %0d expected 2049 1", wr_sec_addr, wr_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] wrap_hist;
    logic [31:0] exp_addr;
    wrap_hist = 5'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wr_req = 1'b1;
      for (int i = 0; i < 100 && n_wr_done < k + 1; i++) tick();
      wr_req = 1'b0;
      wrap_hist[k] = wrap;
      tick();
    end
    checks++; if (st_kind.size() != 5) begin errors++; $display("FAIL wrap_starts: got %0d expected 5", st_kind.size()); end
    for (int k = 0; k < 5; k++) begin
      exp_addr = (k == 4) ? 32'd2048 : 32'd2048 + k;
      checks++;
      if (st_addr[k] !== exp_addr) begin
        errors++; $display("FAIL wrap_addr%0d: got %0d expected %0d", k, st_addr[k], exp_addr);
      end
    end
    checks++; if (wrap_hist !== 5'b11000) begin errors++; $display("FAIL wrap_history: got %b expected 11000", wrap_hist); end
    checks++; if (wr_cnt !== 32'd5) begin errors++; $display("FAIL wrap_wr_cnt: got %0d expected 5", wr_cnt); end
    checks++; if (wr_sec_addr !== 32'd2049) begin errors++; $display("FAIL wrap_next_addr: got %0d expected 2049", wr_sec_addr); end
  endtask

  // Continues from the wrapped state left by test_wrap.
  task automatic test_async_reset();
    wr_req = 1'b1;
    for (int i = 0; i < 50 && wr_busy !== 1'b1; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_sec_addr !== 32'd2048) begin errors++; $display("FAIL areset_addr: got %0d expected 2048", wr_sec_addr); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap: got %b expected 0", wrap); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL areset_wr_cnt: got %0d expected 0", wr_cnt); end
    checks++;
    if ({wr_start_en, rd_start_en, wr_done, rd_done, err_to} !== 5'b0 || rd_sec_addr !== 32'd0) begin
      errors++;
      $display("FAIL areset_outputs: got pulses %b rd_addr %0d expected 00000 0",
               {wr_start_en, rd_start_en, wr_done, rd_done, err_to}, rd_sec_addr);
    end
    wr_req = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_timeout();
    test_init_drop();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_rw_sched.md
Name: sd_rw_sched

Overview:
- Scheduler in front of the SD card controller top. Shares the card between two requesters:
  - the acquisition path, which writes whole sectors;
  - the readback path, which reads whole sectors.
- Issues single-cycle start pulses to the controller and waits out the controller's busy handshake.
- Owns the write sector address as a ring-buffer pointer and reports completion, timeout and wrap status.

Parameters:
- SEC_START, 32'd2048: first sector of the write ring.
- SEC_NUM, 32'd1024: number of sectors in the write ring (>=1).
- BUSY_TO, 16'd50000: clk_ref cycles to wait for busy to assert after a start pulse.

Ports:
- clk_ref  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- sd_init_done  in  1  card initialised; no transaction is granted while low
- wr_req  in  1  acquisition requester: one sector staged; held high until wr_done
- wr_done  out  1  one-cycle pulse: requested sector written
- rd_req  in  1  readback requester; held high until rd_done
- rd_addr  in  32  sector to read; sampled on grant
- rd_done  out  1  one-cycle pulse: sector read complete
- wr_start_en  out  1  to controller: write start pulse
- wr_sec_addr  out  32  to controller: write sector address
- wr_busy  in  1  from controller
- rd_start_en  out  1  to controller: read start pulse
- rd_sec_addr  out  32  to controller: read sector address
- rd_busy  in  1  from controller
- err_to  out  1  one-cycle pulse: busy never asserted within BUSY_TO
- wrap  out  1  sticky: write pointer has wrapped at least once
- wr_cnt  out  32  total sectors written since reset (saturates at 32'hFFFF_FFFF)

Behaviour:
- Reset values (asynchronous): state=IDLE; wr_sec_addr=SEC_START; rd_sec_addr=0; all pulses=0; wrap=0; wr_cnt=0; last_grant=RD, so write wins the first tie. All outputs are registered.
- States: IDLE, WR_GO, WR_WBSY, WR_WDONE, RD_GO, RD_WBSY, RD_WDONE.
- IDLE arbitration:
  - Only when sd_init_done=1 and both wr_busy=0 and rd_busy=0.
  - One request pending: grant it.
  - Both pending: round-robin, grant the opposite of last_grant.
  - On a read grant, rd_sec_addr<=rd_addr in the same edge.
  - Next state is WR_GO or RD_GO; last_grant is updated.
- WR_GO / RD_GO: the matching start_en is high for exactly this one cycle. Next state is *_WBSY and the timeout counter clears to 0.
- *_WBSY:
  - Matching busy=1 -> *_WDONE.
  - Otherwise the counter increments. When it reaches BUSY_TO-1 with busy still 0: err_to pulses for 1 cycle and the state returns to IDLE.
  - On timeout there is no done pulse, no address change and no wr_cnt change; the request stays pending and is re-arbitrated.
- *_WDONE: on the matching busy falling (busy=0), pulse wr_done or rd_done for 1 cycle and go to IDLE. No timeout in this state; the controller guarantees completion.
- Write completion bookkeeping, on the wr_done edge:
  - If wr_sec_addr == SEC_START+SEC_NUM-1: wr_sec_addr<=SEC_START and wrap<=1.
  - Otherwise wr_sec_addr<=wr_sec_addr+1.
  - wr_cnt increments, saturating.
  - All address arithmetic is 32-bit unsigned; SEC_START+SEC_NUM-1 is a constant.
- Latency: request high in IDLE -> start pulse 2 edges later (grant edge, then GO cycle). Busy falling -> done pulse on the next edge.
- Back-to-back: IDLE is visited for at least 1 cycle between transactions. A requester must drop its req within 1 cycle of done, or it is re-granted.
- wr_sec_addr is stable from the grant until the done pulse and never changes while wr_busy=1. rd_sec_addr is stable from the grant until rd_done.
- sd_init_done falling in any non-IDLE state: abort to IDLE with no done pulse and no bookkeeping; pending requests are held.
- Busy asserted in IDLE (foreign activity): no grant until it is low.
- A request that drops before grant is ignored. A request that drops after grant is ignored; the transaction completes and done still pulses.

Test Plan:
1. Reset, sd_init_done=1, wr_req held. Model busy high 3 cycles after start for 10 cycles -> wr_start_en pulses once with wr_sec_addr=2048; wr_done pulses 1 cycle after busy falls; then wr_sec_addr=2049 and wr_cnt=1.
2. wr_req and rd_req (rd_addr=0x10) both high continuously, each acked -> grant order W,R,W,R; rd_sec_addr=0x10 during reads.
3. SEC_NUM=4, issue 5 writes -> addresses 2048,2049,2050,2051,2048; wrap rises on the 4th wr_done; wr_cnt=5.
4. BUSY_TO=16, rd_busy never asserts -> err_to pulses 16 cycles after the GO cycle; no rd_done; rd_start_en re-pulses on retry.
5. Drop sd_init_done during WR_WDONE -> state returns to IDLE; no wr_done; wr_sec_addr unchanged; no grant while sd_init_done=0.
6. Assert rst_n=0 mid-write -> all outputs return to their reset values immediately (asynchronously), wr_sec_addr=2048 and wrap=0.
